// File: rtl/dsp_mac_pipe_if.sv
// Data/handshake bundle of the dsp_mac_pipe slice: operand inputs, clock enable and
// the registered result. The slice itself sits on the slave side.
interface dsp_mac_pipe_if #(
    parameter int A_W = 18,
    parameter int B_W = 18,
    parameter int D_W = 18,
    parameter int C_W = 48,
    parameter int P_W = 48
) ();
    logic                  ce;
    logic                  in_valid;
    logic signed [A_W-1:0] A;
    logic signed [B_W-1:0] B;
    logic signed [C_W-1:0] C;
    logic signed [D_W-1:0] D;
    logic [3:0]            opmode;
    logic                  out_valid;
    logic [P_W-1:0]        P;
    logic                  ovf;

    modport master (
        output ce, in_valid, A, B, C, D, opmode,
        input  out_valid, P, ovf
    );

    modport slave (
        input  ce, in_valid, A, B, C, D, opmode,
        output out_valid, P, ovf
    );
endinterface

// File: rtl/dsp_mac_pipe.sv
// Four-stage signed pre-add / multiply / post-add slice with accumulate, valid tracking,
// clock-enable stall and a registered signed-overflow flag.
module dsp_mac_pipe #(
    parameter int A_W = 18,
    parameter int B_W = 18,
    parameter int D_W = 18,
    parameter int C_W = 48,
    parameter int P_W = 48
) (
    input logic           clk,
    input logic           rst,
    dsp_mac_pipe_if.slave bus
);
    localparam int PRE_W = ((B_W > D_W) ? B_W : D_W) + 1;
    localparam int M_W   = A_W + PRE_W;

    // Stage 1: input registers
    logic                  v1;
    logic signed [A_W-1:0] a1;
    logic signed [B_W-1:0] b1;
    logic signed [C_W-1:0] c1;
    logic signed [D_W-1:0] d1;
    logic [3:0]            op1;

    // Stage 2: pre-adder result
    logic                    v2;
    logic signed [A_W-1:0]   a2;
    logic signed [PRE_W-1:0] pre2;
    logic signed [C_W-1:0]   c2;
    logic [1:0]              post2;

    // Stage 3: product
    logic                  v3;
    logic signed [P_W-1:0] m3;
    logic signed [P_W-1:0] c3;
    logic [1:0]            post3;

    // Stage 4: result register
    logic                  vout;
    logic signed [P_W-1:0] p_q;
    logic                  ovf_q;

    logic signed [PRE_W-1:0] b_ext;
    logic signed [PRE_W-1:0] d_ext;
    logic signed [PRE_W-1:0] pre_nxt;
    logic signed [M_W-1:0]   a_mul;
    logic signed [M_W-1:0]   pre_mul;
    logic signed [M_W-1:0]   prod;
    logic signed [P_W-1:0]   m_nxt;
    logic signed [P_W-1:0]   c_nxt;
    logic signed [P_W-1:0]   x_op;
    logic signed [P_W-1:0]   y_op;
    logic signed [P_W-1:0]   sum;
    logic                    sub;
    logic                    ovf_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1  <= 1'b0;
            a1  <= '0;
            b1  <= '0;
            c1  <= '0;
            d1  <= '0;
            op1 <= '0;
        end else if (bus.ce) begin
            v1 <= bus.in_valid;
            if (bus.in_valid) begin
                a1  <= bus.A;
                b1  <= bus.B;
                c1  <= bus.C;
                d1  <= bus.D;
                op1 <= bus.opmode;
            end
        end
    end

    // One guard bit above the wider operand keeps the pre-adder from wrapping.
    always_comb begin
        b_ext   = PRE_W'(b1);
        d_ext   = PRE_W'(d1);
        pre_nxt = b_ext;
        if (op1[1]) begin
            pre_nxt = op1[0] ? (d_ext - b_ext) : (d_ext + b_ext);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v2    <= 1'b0;
            a2    <= '0;
            pre2  <= '0;
            c2    <= '0;
            post2 <= '0;
        end else if (bus.ce) begin
            v2 <= v1;
            if (v1) begin
                a2    <= a1;
                pre2  <= pre_nxt;
                c2    <= c1;
                post2 <= op1[3:2];
            end
        end
    end

    // Full-width signed product, then fitted (extended or truncated) to P_W.
    always_comb begin
        a_mul   = M_W'(a2);
        pre_mul = M_W'(pre2);
        prod    = a_mul * pre_mul;
        m_nxt   = P_W'(prod);
        c_nxt   = P_W'(c2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v3    <= 1'b0;
            m3    <= '0;
            c3    <= '0;
            post3 <= '0;
        end else if (bus.ce) begin
            v3 <= v2;
            if (v2) begin
                m3    <= m_nxt;
                c3    <= c_nxt;
                post3 <= post2;
            end
        end
    end

    // Accumulate modes take the live P register as the left operand.
    always_comb begin
        sub  = post3[0];
        x_op = post3[1] ? p_q : m3;
        y_op = post3[1] ? m3  : c3;
        sum  = sub ? (x_op - y_op) : (x_op + y_op);
        if (sub) begin
            ovf_nxt = (x_op[P_W-1] != y_op[P_W-1]) && (sum[P_W-1] != x_op[P_W-1]);
        end else begin
            ovf_nxt = (x_op[P_W-1] == y_op[P_W-1]) && (sum[P_W-1] != x_op[P_W-1]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vout  <= 1'b0;
            p_q   <= '0;
            ovf_q <= 1'b0;
        end else if (bus.ce) begin
            vout <= v3;
            if (v3) begin
                p_q   <= sum;
                ovf_q <= ovf_nxt;
            end
        end
    end

    assign bus.out_valid = vout;
    assign bus.P         = p_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Bench for dsp_mac_pipe: directed scenarios plus a randomised stream scored against an
// arithmetic reference model of the slice.
module tb_dsp_mac_pipe;
    localparam int A_W = 18;
    localparam int B_W = 18;
    localparam int D_W = 18;
    localparam int C_W = 48;
    localparam int P_W = 48;
    localparam longint PMAX = 64'sh0000_7FFF_FFFF_FFFF;
    localparam longint PMIN = -PMAX - 1;

    typedef struct packed {
        logic [47:0] p;
        logic        ovf;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dsp_mac_pipe_if #(.A_W(A_W), .B_W(B_W), .D_W(D_W), .C_W(C_W), .P_W(P_W)) bus ();

    dsp_mac_pipe #(.A_W(A_W), .B_W(B_W), .D_W(D_W), .C_W(C_W), .P_W(P_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int     checks = 0;
    int     errors = 0;
    longint p_model = 0;
    res_t   expq[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands, true-range overflow test.
    task automatic model_push(input logic signed [17:0] a, input logic signed [17:0] b,
                              input logic signed [17:0] d, input logic signed [47:0] c,
                              input logic [3:0] op);
        longint pre;
        longint m;
        longint r;
        res_t   e;
        if (op[1]) pre = op[0] ? (longint'(d) - longint'(b)) : (longint'(d) + longint'(b));
        else       pre = longint'(b);
        m = longint'(a) * pre;
        case (op[3:2])
            2'd0:    r = m + longint'(c);
            2'd1:    r = m - longint'(c);
            2'd2:    r = p_model + m;
            default: r = p_model - m;
        endcase
        e.ovf   = (r > PMAX) || (r < PMIN);
        e.p     = r[47:0];
        p_model = longint'($signed(e.p));
        expq.push_back(e);
    endtask

    task automatic cyc(input logic c_en, input logic v, input logic signed [17:0] a,
                       input logic signed [17:0] b, input logic signed [17:0] d,
                       input logic signed [47:0] c, input logic [3:0] op);
        bus.ce       = c_en;
        bus.in_valid = v;
        bus.A        = a;
        bus.B        = b;
        bus.D        = d;
        bus.C        = c;
        bus.opmode   = op;
        if (c_en && v && !rst) model_push(a, b, d, c, op);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b1, 1'b0, '0, '0, '0, '0, '0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        expq.delete();
        p_model = 0;
        repeat (2) cyc(1'b1, 1'b1, 18'($urandom), 18'($urandom), 18'($urandom),
                       48'({$urandom, $urandom}), 4'($urandom));
        rst = 1'b0;
        chk("reset_P", 64'(bus.P), 64'(0));
        chk("reset_out_valid", 64'(bus.out_valid), 64'(0));
        chk("reset_ovf", 64'(bus.ovf), 64'(0));
    endtask

    // Scoreboard: a result is consumed on a cycle with out_valid=1 and ce=1.
    always @(negedge clk) begin
        res_t e;
        if (rst !== 1'b1 && bus.ce === 1'b1 && bus.out_valid === 1'b1) begin
            checks++;
            assert (expq.size() != 0) else begin
                errors++;
                $error("FAIL spurious_result observed=%h expected=none", bus.P);
            end
            if (expq.size() != 0) begin
                e = expq.pop_front();
                chk("stream_P", 64'(bus.P), 64'(e.p));
                chk("stream_ovf", 64'(bus.ovf), 64'(e.ovf));
            end
        end
    end

    logic signed [17:0] a5[8];
    logic signed [17:0] b5[8];
    logic signed [17:0] d5[8];
    logic signed [47:0] c5[8];
    logic [3:0]         op5[8];
    logic [49:0]        obs0[16];
    logic [49:0]        obs1[16];
    int                 exp_acc[2][6] = '{'{6, 12, 18, 24, 30, 30}, '{6, 12, 12, 18, 24, 30}};
    int                 exp_accv[2][6] = '{'{1, 1, 1, 1, 1, 0}, '{1, 1, 0, 1, 1, 1}};

    initial begin
        bus.ce = 1'b0; bus.in_valid = 1'b0; bus.A = '0; bus.B = '0;
        bus.C = '0; bus.D = '0; bus.opmode = '0;

        do_reset();

        // Basic pre-add multiply post-add with latency check
        cyc(1'b1, 1'b1, 18'sd3, 18'sd4, 18'sd5, 48'sd10, 4'b0010);
        chk("lat_c1", 64'(bus.out_valid), 64'(0));
        idle(1);
        chk("lat_c2", 64'(bus.out_valid), 64'(0));
        idle(1);
        chk("lat_c3", 64'(bus.out_valid), 64'(0));
        idle(1);
        chk("lat_c4_valid", 64'(bus.out_valid), 64'(1));
        chk("basic_P", 64'(bus.P), 64'(37));
        chk("basic_ovf", 64'(bus.ovf), 64'(0));

        // Pre-subtract gives a negative product
        cyc(1'b1, 1'b1, 18'sd4, 18'sd5, 18'sd2, 48'sd0, 4'b0011);
        idle(3);
        chk("presub_P", 64'(bus.P), 64'(48'hFFFF_FFFF_FFF4));
        chk("presub_ovf", 64'(bus.ovf), 64'(0));

        // Accumulate chain, without and with a bubble
        for (int run = 0; run < 2; run++) begin
            cyc(1'b1, 1'b1, 18'sd0, 18'sd0, 18'sd0, 48'sd0, 4'b0000);
            idle(3);
            chk("acc_preload", 64'(bus.P), 64'(0));
            for (int s = 0; s < 9; s++) begin
                logic iss;
                iss = (run == 0) ? (s < 5) : (s < 6 && s != 2);
                cyc(1'b1, iss, 18'sd2, 18'sd3, 18'sd0, 48'sd0, 4'b1000);
                if (s >= 3) begin
                    chk($sformatf("acc_r%0d_s%0d_P", run, s), 64'(bus.P),
                        64'(48'(exp_acc[run][s-3])));
                    chk($sformatf("acc_r%0d_s%0d_v", run, s), 64'(bus.out_valid),
                        64'(exp_accv[run][s-3]));
                end
            end
        end

        // Stall: the ce-dropped run must equal the free run shifted by 3 cycles
        for (int i = 0; i < 8; i++) begin
            a5[i]  = 18'($urandom);
            b5[i]  = 18'($urandom);
            d5[i]  = 18'($urandom);
            c5[i]  = 48'({$urandom, $urandom});
            op5[i] = {2'b00, 2'($urandom)};
        end
        do_reset();
        for (int s = 0; s < 13; s++) begin
            if (s < 8) cyc(1'b1, 1'b1, a5[s], b5[s], d5[s], c5[s], op5[s]);
            else       idle(1);
            obs0[s] = {bus.ovf, bus.out_valid, bus.P};
        end
        do_reset();
        begin
            int k;
            k = 0;
            for (int s = 0; s < 16; s++) begin
                logic en;
                int   ref_s;
                en = !(s >= 5 && s < 8);
                if (k < 8) begin
                    cyc(en, 1'b1, a5[k], b5[k], d5[k], c5[k], op5[k]);
                    if (en) k++;
                end else begin
                    cyc(en, 1'b0, '0, '0, '0, '0, '0);
                end
                obs1[s] = {bus.ovf, bus.out_valid, bus.P};
                ref_s = (s < 5) ? s : ((s < 8) ? 4 : s - 3);
                chk($sformatf("stall_s%0d", s), 64'(obs1[s]), 64'(obs0[ref_s]));
            end
        end

        // Signed overflow of the post-adder, then cleared by the next item
        cyc(1'b1, 1'b1, 18'sd1, 18'sd1, 18'sd0, 48'sh7FFF_FFFF_FFFF, 4'b0000);
        cyc(1'b1, 1'b1, 18'sd1, 18'sd1, 18'sd0, 48'sd0, 4'b0000);
        idle(2);
        chk("ovf_P", 64'(bus.P), 64'(48'h8000_0000_0000));
        chk("ovf_set", 64'(bus.ovf), 64'(1));
        idle(1);
        chk("ovf_next_P", 64'(bus.P), 64'(1));
        chk("ovf_clear", 64'(bus.ovf), 64'(0));

        // Reset mid-stream discards in-flight items
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 1'b1, 18'($urandom), 18'($urandom), 18'($urandom),
                48'({$urandom, $urandom}), 4'($urandom));
        do_reset();
        for (int i = 0; i < 6; i++) begin
            idle(1);
            chk($sformatf("post_reset_quiet%0d", i), 64'(bus.out_valid), 64'(0));
        end

        // Randomised stream with random stalls and bubbles
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7,
                18'($urandom), 18'($urandom), 18'($urandom),
                48'({$urandom, $urandom}), 4'($urandom));
        end
        idle(6);
        chk("drain_empty", 64'(expq.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
